lut_config_pipe: RTL and testbench
==================================

Name: lut_config_pipe

Overview:
- Parametrised K-input lookup table whose truth table is loaded at run time over a beat-wise valid/ready config port.
- Lookups are registered.
- Config writes go to a shadow table and are committed atomically, so lookups never see a half-loaded table.
- Generalises the fixed combinational LUT mux into a reconfigurable, pipelined LUT tile for the lut-tests fabric.

Parameters:
- INPUTS, 4, number of select inputs (K); legal range 1..8 (2..8 with PREDECODE_EN).
- WIDTH, 1<<INPUTS, truth-table bits; not overridden independently.
- CFG_WIDTH, 4, config bits per beat; WIDTH must be an integer multiple of CFG_WIDTH.
- BEATS, WIDTH/CFG_WIDTH, derived beat count per full load.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accept.
- cfg_data  in  CFG_WIDTH  config beat payload.
- cfg_abort  in  1  discard a partially loaded shadow table.
- cfg_done  out  1  one-cycle pulse when a new table becomes active.
- s_valid  in  1  lookup request valid.
- s  in  INPUTS  lookup select.
- z_valid  out  1  lookup result valid.
- z  out  1  lookup result.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - active table, shadow table and beat counter to 0.
  - FSM to IDLE.
  - Outputs: cfg_ready=1, cfg_done=0, z_valid=0, z=0.
  - All pipeline stages are flushed.
- Beat transfer occurs when cfg_valid && cfg_ready at a clk edge.
- Beat n (0-based) writes shadow[n*CFG_WIDTH +: CFG_WIDTH]; beat 0 holds the table LSBs.
- FSM:
  - IDLE: cfg_ready=1, counter=0.
    - On transfer: write beat 0; go to COMMIT if BEATS==1, else LOAD with counter=1.
  - LOAD: cfg_ready=1.
    - On transfer: write beat[counter] and increment counter.
    - On the transfer of beat BEATS-1, go to COMMIT.
  - COMMIT: single cycle, cfg_ready=0.
    - active <= shadow at the end of the cycle; cfg_done=1 during the cycle; counter <= 0; go to IDLE.
- cfg_abort:
  - In IDLE or LOAD: counter <= 0, shadow <= 0, FSM to IDLE. Abort wins over a same-cycle transfer, and that beat is dropped.
  - In COMMIT: ignored; the commit completes.
- cfg_valid with no transfer: no state change. Data sampled only on transfer.
- Lookup, baseline:
  - On each clk edge: z_valid <= s_valid; z <= active[s] when s_valid, else z holds its value.
  - Latency 1 cycle; accepts one lookup per cycle, no backpressure.
- Lookup/commit interaction: a lookup sampled in the COMMIT cycle uses the old table. Lookups from the next cycle onward use the new table.
- Active table is never partially updated.
- The lookup path is independent of the config FSM state; lookups continue during LOAD.

Optional Feature:
- Macro: LUT_PREDECODE_EN.
- Defined: the lookup is a 2-stage pipeline.
  - Stage 1 registers grp = active[s[INPUTS-1:2]*4 +: 4], the one-hot decode oh of s[1:0] (00->0001, 01->0010, 10->0100, 11->1000), and v1=s_valid.
  - Stage 2 registers z <= |(grp & oh) and z_valid <= v1.
  - Latency 2 cycles, throughput 1 per cycle.
  - The table is sampled at stage 1: a lookup sampled in the COMMIT cycle uses the old table even though its result emerges after the commit.
  - Requires INPUTS>=2.
  - Reset clears grp, oh and v1 to 0.
- Undefined: baseline single-stage lookup, latency 1.

Test Plan:
- Reset, then s_valid=1 sweeping s=0..15 -> z=0 for all 16; z_valid follows s_valid 1 cycle later (2 with LUT_PREDECODE_EN).
- Load 4 beats 0x1, 0x2, 0x4, 0x8 (table 0x8421) -> cfg_done pulses exactly one cycle after the 4th transfer, with cfg_ready=0 in that cycle. Afterwards z=1 only for s=0, 5, 10, 15.
- Issue a lookup s=0 in the COMMIT cycle of a load replacing 0x0000 with 0xFFFF -> that result z=0; a lookup s=0 on the next cycle -> z=1.
- After 2 beats (0xF, 0xF), assert cfg_abort together with a valid 3rd beat. Then:
  - The beat is dropped, the FSM is in IDLE, the active table is unchanged, and no cfg_done pulse occurs.
  - A fresh 4-beat load of 0xA5A5 commits correctly.
- Insert cfg_valid gaps between beats (random 0-3 idle cycles) while running continuous lookups -> the final table equals the beats as sent; lookups during LOAD return the old table.
- Assert rst_n=0 mid-LOAD after 3 beats of 0xF -> the active table reads 0, cfg_ready=1, z_valid=0 on the next cycle, and the counter restarts at beat 0.

Source files
------------

// File: rtl/lut_config_pipe.sv
// lut_config_pipe
//   Reconfigurable K-input lookup table tile. The truth table is streamed in
//   over a beat-wise config port into a shadow copy. Once the last beat has
//   arrived, one COMMIT cycle copies the shadow into the active table. A
//   lookup therefore only ever sees a complete table.
//
//   Optional build macro: LUT_PREDECODE_EN
//     undefined : single-stage registered lookup, latency 1
//     defined   : two-stage lookup (4-bit group select + one-hot decode of
//                 s[1:0]), latency 2. Requires INPUTS >= 2.
//
//   Handshake: a config beat transfers on a rising clk edge where
//   cfg_valid && cfg_ready. cfg_data is sampled only on a transfer.
//   cfg_valid held without cfg_ready has no effect. The lookup port has no
//   backpressure: every s_valid cycle yields one z_valid cycle.
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset
//     cfg_valid  in   config beat valid
//     cfg_ready  out  config beat accept (low only in the COMMIT cycle)
//     cfg_data   in   config beat payload; beat 0 holds the table LSBs
//     cfg_abort  in   discard a partially loaded shadow table
//     cfg_done   out  one-cycle pulse while the new table is committed
//     s_valid    in   lookup request valid
//     s          in   lookup select
//     z_valid    out  lookup result valid
//     z          out  lookup result
module lut_config_pipe #(
    parameter int INPUTS    = 4,
    parameter int CFG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CFG_WIDTH-1:0] cfg_data,
    input  logic                 cfg_abort,
    output logic                 cfg_done,
    input  logic                 s_valid,
    input  logic [INPUTS-1:0]    s,
    output logic                 z_valid,
    output logic                 z
);

    localparam int WIDTH = 1 << INPUTS;
    localparam int BEATS = WIDTH / CFG_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [WIDTH-1:0]   shadow;
    logic [WIDTH-1:0]   active;
    logic               beat_we;
    logic               shadow_clr;
    logic               commit;

    // ------------------------------------------------------------------
    // Config FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cfg_ready is high in every state except COMMIT, so inside IDLE/LOAD a
    // transfer is simply cfg_valid.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cfg_ready  = 1'b1;
        cfg_done   = 1'b0;
        beat_we    = 1'b0;
        shadow_clr = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (cfg_abort) begin
                    // Abort wins; any same-cycle beat is dropped.
                    shadow_clr = 1'b1;
                end else if (cfg_valid) begin
                    beat_we = 1'b1;
                    if (BEATS == 1) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = LOAD;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    shadow_clr = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cfg_valid) begin
                    beat_we = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_next = COMMIT;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                // Abort is ignored here: the commit always completes.
                cfg_ready  = 1'b0;
                cfg_done   = 1'b1;
                commit     = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow and active tables
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (shadow_clr) begin
                shadow <= '0;
            end else if (beat_we) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (cnt == CNT_W'(b)) begin
                        shadow[b*CFG_WIDTH +: CFG_WIDTH] <= cfg_data;
                    end
                end
            end
            // The whole table moves in one edge, so a lookup sampled in the
            // COMMIT cycle still reads the old contents.
            if (commit) begin
                active <= shadow;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup path (independent of the config FSM)
    // ------------------------------------------------------------------
`ifdef LUT_PREDECODE_EN
    logic [3:0] grp;
    logic [3:0] oh;
    logic       v1;

    // Stage 1 picks the 4-bit group addressed by the upper select bits and
    // one-hot decodes the lower two. The table is sampled here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp <= '0;
            oh  <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= s_valid;
            if (s_valid) begin
                grp <= active[{s[INPUTS-1:2], 2'b00} +: 4];
                oh  <= 4'b0001 << s[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_valid <= 1'b0;
            z       <= 1'b0;
        end else begin
            z_valid <= v1;
            if (v1) begin
                z <= |(grp & oh);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_valid <= 1'b0;
            z       <= 1'b0;
        end else begin
            z_valid <= s_valid;
            if (s_valid) begin
                z <= active[s];
            end
        end
    end
`endif

endmodule

// File: tb/tb_lut_config_pipe.sv
// Testbench for lut_config_pipe (default parameters: INPUTS=4, CFG_WIDTH=4).
module tb_lut_config_pipe;

  localparam int INPUTS = 4;
  localparam int CFG_W  = 4;
  localparam int WIDTH  = 16;
  localparam int BEATS  = WIDTH / CFG_W;
`ifdef LUT_PREDECODE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CFG_W-1:0]  cfg_data;
  logic              cfg_abort;
  logic              cfg_done;
  logic              s_valid;
  logic [INPUTS-1:0] s;
  logic              z_valid;
  logic              z;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  lut_config_pipe #(.INPUTS(INPUTS), .CFG_WIDTH(CFG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_abort (cfg_abort),
    .cfg_done  (cfg_done),
    .s_valid   (s_valid),
    .s         (s),
    .z_valid   (z_valid),
    .z         (z)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp;
  int n_err;
  logic [0:0] exp_q[$];
  int         lk_s[$];
  logic       lk_exp[$];
  bit         lk_rand;
  logic       smp_ready;
  logic       smp_done;

  // ---------------- reference model ----------------
  // Beats collect in a queue; a full queue means the next cycle commits.
  logic [WIDTH-1:0] m_active;
  logic [CFG_W-1:0] m_beats[$];
  bit               m_commit;
  logic             m_zv, m_z;
  logic             m_pv, m_pz;

  function automatic logic [WIDTH-1:0] pack_beats();
    logic [WIDTH-1:0] t;
    t = '0;
    for (int b = 0; b < m_beats.size(); b++) t[b*CFG_W +: CFG_W] = m_beats[b];
    return t;
  endfunction

  task automatic model_reset();
    m_active = '0;
    m_beats.delete();
    m_commit = 0;
    m_zv = 0; m_z = 0; m_pv = 0; m_pz = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef LUT_PREDECODE_EN
      m_zv = m_pv;
      if (m_pv) m_z = m_pz;
      m_pv = s_valid;
      if (s_valid) m_pz = m_active[s];
`else
      m_zv = s_valid;
      if (s_valid) m_z = m_active[s];
`endif
      if (m_commit) begin
        m_active = pack_beats();
        m_beats.delete();
        m_commit = 0;
      end else if (cfg_abort) begin
        m_beats.delete();
      end else if (cfg_valid) begin
        m_beats.push_back(cfg_data);
        if (m_beats.size() == BEATS) m_commit = 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; combinational config outputs
  // are sampled at the falling edge, registered outputs 1 ns after the rise.
  task automatic tick();
    if (lk_rand) begin
      s_valid = 1'($urandom_range(0, 1));
      s       = INPUTS'($urandom);
    end
    @(negedge clk);
    smp_ready = cfg_ready;
    smp_done  = cfg_done;
    check("model_cfg_ready", 32'(cfg_ready), 32'(!m_commit));
    check("model_cfg_done", 32'(cfg_done), 32'(m_commit));
    @(posedge clk);
    model_edge();
    #1;
    check("model_z_valid", 32'(z_valid), 32'(m_zv));
    check("model_z", 32'(z), 32'(m_z));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [CFG_W-1:0] d, input int gap);
    cfg_valid = 1'b0;
    repeat (gap) tick();
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load_table(input logic [WIDTH-1:0] tbl, input int max_gap, input bit do_commit);
    for (int b = 0; b < BEATS; b++) send_beat(tbl[b*CFG_W +: CFG_W], $urandom_range(0, max_gap));
    if (do_commit) tick();
  endtask

  // Applies lk_s[] back to back and checks each result against lk_exp[]
  // once it emerges LAT cycles later.
  task automatic lookup_seq(input string name);
    int n;
    n = lk_s.size();
    for (int i = 0; i < n + LAT - 1; i++) begin
      if (i < n) begin
        s_valid = 1'b1;
        s       = INPUTS'(lk_s[i]);
        exp_q.push_back(lk_exp[i]);
      end else begin
        s_valid = 1'b0;
      end
      tick();
      if (i >= LAT - 1) begin
        check({name, "_z"}, 32'(z), 32'(exp_q.pop_front()));
        check({name, "_zv"}, 32'(z_valid), 32'd1);
      end
    end
    s_valid = 1'b0;
    lk_s.delete();
    lk_exp.delete();
  endtask

  task automatic sweep(input logic [WIDTH-1:0] tbl, input string name);
    for (int i = 0; i < WIDTH; i++) begin
      lk_s.push_back(i);
      lk_exp.push_back(tbl[i]);
    end
    lookup_seq(name);
  endtask

  // ---------------- test vectors ----------------
  typedef struct packed {
    logic [3:0] sel;
    logic       exp_z;
  } vec_t;
  vec_t vecs[16];

  initial begin
    logic [WIDTH-1:0] rtbl;
    n_cmp = 0;
    n_err = 0;
    lk_rand = 0;

    for (int i = 0; i < 16; i++) begin
      vecs[i].sel   = 4'(i);
      vecs[i].exp_z = (i == 0 || i == 5 || i == 10 || i == 15);
    end

    // Reset
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_abort = 1'b0;
    s_valid = 1'b0; s = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_z_valid", 32'(z_valid), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    rst_n = 1'b1;

    // Empty table after reset
    sweep(16'h0000, "zero_sweep");

    // Load 0x8421 beat by beat; cfg_done must pulse in the cycle after beat 4
    send_beat(4'h1, 0);
    send_beat(4'h2, 0);
    send_beat(4'h4, 0);
    check("b3_ready_before", 32'(smp_ready), 32'd1);
    send_beat(4'h8, 0);
    check("b4_done_low", 32'(smp_done), 32'd0);
    tick();
    check("commit_done", 32'(smp_done), 32'd1);
    check("commit_ready", 32'(smp_ready), 32'd0);
    tick();
    check("post_commit_done", 32'(smp_done), 32'd0);
    check("post_commit_ready", 32'(smp_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      lk_s.push_back(int'(vecs[i].sel));
      lk_exp.push_back(vecs[i].exp_z);
    end
    lookup_seq("vec_8421");

    // Abort after two beats with a valid third beat in the same cycle
    send_beat(4'hF, 0);
    send_beat(4'hF, 0);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 4'hF;
    tick();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) begin
      tick();
      check("abort_no_done", 32'(smp_done), 32'd0);
      check("abort_ready", 32'(smp_ready), 32'd1);
    end
    sweep(16'h8421, "abort_keep");
    load_table(16'hA5A5, 0, 1);
    sweep(16'hA5A5, "after_abort");

    // Reset in the middle of a load
    send_beat(4'hF, 0);
    send_beat(4'hF, 0);
    send_beat(4'hF, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_ready", 32'(cfg_ready), 32'd1);
    check("midrst_zv", 32'(z_valid), 32'd0);
    sweep(16'h0000, "midrst_zero");
    load_table(16'h1234, 0, 1);
    sweep(16'h1234, "midrst_reload");

    // Lookup in the COMMIT cycle sees the old table
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    load_table(16'hFFFF, 0, 0);
    lk_s.push_back(0); lk_exp.push_back(1'b0);
    lk_s.push_back(0); lk_exp.push_back(1'b1);
    lookup_seq("commit_edge");

    // Random tables, random beat gaps, continuous random lookups
    for (int t = 0; t < 8; t++) begin
      rtbl = WIDTH'($urandom);
      lk_rand = 1;
      if (t == 3) begin
        send_beat(4'($urandom), 1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
      end
      load_table(rtbl, 3, 1);
      repeat ($urandom_range(0, 3)) tick();
      lk_rand = 0;
      s_valid = 1'b0;
      sweep(rtbl, "rand_tbl");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
